// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer and ISA decoder: field layout,
// control opcodes and the sequencer state encoding.
package fetch_sequencer_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 32;
  localparam int OPC_LSB = 0;
  localparam int OPC_W   = 7;
  localparam int TGT_LSB = 7;

  localparam logic [OPC_W-1:0] HALT_OP = 7'b1010101;
  localparam logic [OPC_W-1:0] JMP_OP  = 7'b1101111;
  localparam logic [OPC_W-1:0] BR_OP   = 7'b1100011;

  typedef logic [OPC_W-1:0] opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_EX,
    HALTED
  } state_t;

  function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] word);
    return word[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [ADDR_W-1:0] get_target(input logic [INSTR_W-1:0] word);
    return word[TGT_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Next program address: jump/taken-branch target, otherwise pc+1 wrapping
// modulo 2^ADDR_W. Unknown opcodes fall through as sequential.
module next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] target,
  input  logic              br_cond,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc
);

  always_comb begin
    // NOTE: default assignment first so every path drives next_pc and no latch is inferred.
    next_pc = pc + ADDR_W'(1);
    if (opcode == JMP_OP || (opcode == BR_OP && br_cond)) begin
      next_pc = target;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction sequencer: owns the pc, fetches over a req/ack handshake,
// issues one-cycle pulses to the datapath and redirects on jump/branch/halt.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               ex_done,
  input  logic               br_cond,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               busy
);

  state_t            state;
  opcode_t           opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] next_pc;

  assign opcode    = get_opcode(instr);
  assign target    = get_target(instr);
  assign imem_addr = pc;

  next_pc_calc u_next_pc (
    .opcode  (opcode),
    .target  (target),
    .br_cond (br_cond),
    .pc      (pc),
    .next_pc (next_pc)
  );

  // Outputs are registered alongside the state so they are valid for the whole
  // cycle the FSM spends in the corresponding state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          instr_valid <= 1'b0;
          if (opcode == HALT_OP) begin
            state  <= HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= WAIT_EX;
          end
        end
        WAIT_EX: begin
          if (ex_done) begin
            pc       <= next_pc;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-level model predicts the
// issue stream; a monitor compares every fetch and issue against it.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam logic [6:0] ADD_OP = 7'b0110011;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                imem_req;
  logic [ADDR_W-1:0]   imem_addr;
  logic                imem_ack;
  logic [INSTR_W-1:0]  imem_data;
  logic [INSTR_W-1:0]  instr;
  logic                instr_valid;
  logic                ex_done;
  logic                br_cond;
  logic [ADDR_W-1:0]   pc;
  logic                halted;
  logic                busy;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .ex_done     (ex_done),
    .br_cond     (br_cond),
    .pc          (pc),
    .halted      (halted),
    .busy        (busy)
  );

  typedef struct {
    int          addr;
    logic [31:0] word;
  } issue_t;

  issue_t      exp_q[$];
  bit          br_q[$];
  logic [31:0] mem [32];

  int n_checks = 0;
  int n_err    = 0;

  int ack_delay  = 0;
  int ex_delay   = 0;
  bit rand_delay = 1'b0;
  bit late_ack   = 1'b0;
  bit exp_halt   = 1'b0;
  int halt_addr  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input int tgt);
    logic [31:0] w;
    w       = $urandom;
    w[6:0]  = op;
    w[11:7] = tgt[4:0];
    return w;
  endfunction

  // Program-level model: walk the program from address 0, choose each branch
  // outcome up front and record the expected issue order.
  task automatic build_expect(input int steps, input int br_mode);
    int          a;
    logic [31:0] w;
    bit          b;
    issue_t      e;
    a        = 0;
    exp_halt = 1'b0;
    for (int s = 0; s < steps; s++) begin
      w      = mem[a];
      e.addr = a;
      e.word = w;
      exp_q.push_back(e);
      if (w[6:0] == HALT_OP) begin
        exp_halt  = 1'b1;
        halt_addr = a;
        break;
      end
      if (br_mode == 0) b = 1'($urandom_range(0, 1));
      else              b = (a == 21);
      br_q.push_back(b);
      if (w[6:0] == JMP_OP || (w[6:0] == BR_OP && b)) a = int'(w[11:7]);
      else                                            a = (a + 1) % 32;
    end
  endtask

  // Instruction memory responder.
  int mem_cnt = 0;
  int mem_cur = 0;
  bit mem_busy = 1'b0;
  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      imem_ack  = 1'b0;
      imem_data = $urandom;
      if (late_ack) begin
        imem_ack = 1'b1;
        late_ack = 1'b0;
      end else if (reset || !imem_req) begin
        mem_busy = 1'b0;
      end else begin
        if (!mem_busy) begin
          mem_busy = 1'b1;
          mem_cnt  = 0;
          mem_cur  = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
        end
        if (mem_cnt >= mem_cur) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          mem_busy  = 1'b0;
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // Datapath responder: ex_done with the model's branch outcome.
  int ex_cnt = 0;
  int ex_cur = 0;
  bit ex_pend = 1'b0;
  initial begin
    ex_done = 1'b0;
    br_cond = 1'b0;
    forever begin
      @(negedge clk);
      ex_done = 1'b0;
      br_cond = 1'($urandom_range(0, 1));
      if (reset) begin
        ex_pend = 1'b0;
      end else if (ex_pend) begin
        if (ex_cnt >= ex_cur) begin
          ex_done = 1'b1;
          br_cond = (br_q.size() != 0) ? br_q.pop_front() : 1'b0;
          ex_pend = 1'b0;
        end else begin
          ex_cnt++;
        end
      end else if (instr_valid && instr[6:0] != HALT_OP) begin
        ex_pend = 1'b1;
        ex_cnt  = 0;
        ex_cur  = rand_delay ? int'($urandom_range(0, 3)) : ex_delay;
      end
    end
  end

  // Monitor: compares fetches and issues against the scoreboard.
  issue_t      mon_e;
  bit          mon_prev_valid = 1'b0;
  logic [31:0] mon_last_word  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_prev_valid = 1'b0;
        mon_last_word  = '0;
      end else begin
        if (imem_req && exp_q.size() != 0) begin
          check("fetch_addr", 32'(imem_addr), 32'(exp_q[0].addr));
          check("instr_held", instr, mon_last_word);
          check("busy_fetch", 32'(busy), 32'd1);
        end
        if (instr_valid) begin
          check("single_pulse", 32'(mon_prev_valid), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_issue got pc=%0d exp no issue at %0t", pc, $time);
          end else begin
            mon_e = exp_q.pop_front();
            check("issue_instr", instr, mon_e.word);
            check("issue_pc", 32'(pc), 32'(mon_e.addr));
            mon_last_word = mon_e.word;
          end
        end
        mon_prev_valid = instr_valid;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    br_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("prog_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_prog(input int steps, input int br_mode, input int exp_req_cycles);
    int n;
    build_expect(steps, br_mode);
    pulse_start();
    if (exp_req_cycles > 0) begin
      n = 0;
      for (int k = 0; k < 50; k++) begin
        if (imem_req) n++;
        else break;
        @(negedge clk);
      end
      check("req_hold_cycles", 32'(n), 32'(exp_req_cycles));
    end
    wait_drain();
    if (exp_halt) begin
      @(negedge clk);
      check("halted", 32'(halted), 32'd1);
      check("busy_halted", 32'(busy), 32'd0);
      check("pc_halted", 32'(pc), 32'(halt_addr));
      check("req_halted", 32'(imem_req), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'd0);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = mk(ADD_OP, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_req", 32'(imem_req), 32'd0);

    // Three sequential instructions then halt at 3.
    mem[3] = mk(HALT_OP, 0);
    run_prog(10, 0, 0);
    do_reset();

    // Jump, not-taken branch, taken branch, halt at 4; then halt stickiness.
    for (int i = 0; i < 32; i++) mem[i] = mk(ADD_OP, $urandom_range(0, 31));
    mem[2]  = mk(JMP_OP, 20);
    mem[20] = mk(BR_OP, 31);
    mem[21] = mk(BR_OP, 3);
    mem[4]  = mk(HALT_OP, 0);
    run_prog(20, 1, 0);
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 1);
      @(negedge clk);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_pc", 32'(pc), 32'd4);
      check("halt_flag", 32'(halted), 32'd1);
    end
    start = 1'b0;
    do_reset();

    // Wrap from 31 to 0.
    for (int i = 0; i < 32; i++) mem[i] = mk(ADD_OP, 0);
    mem[0] = mk(JMP_OP, 31);
    run_prog(5, 0, 0);
    do_reset();

    // Delayed ack: request held six cycles at a constant address.
    ack_delay = 5;
    mem[0] = mk(ADD_OP, 0);
    mem[1] = mk(HALT_OP, 0);
    run_prog(10, 0, 6);
    do_reset();

    // Async reset mid-FETCH, then a stray ack while idle.
    ack_delay = 10;
    pulse_start();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_fetch");
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ack_delay = 0;
    late_ack  = 1'b1;
    repeat (3) @(negedge clk);
    check("late_ack_req", 32'(imem_req), 32'd0);
    check("late_ack_instr", instr, 32'd0);
    check("late_ack_busy", 32'(busy), 32'd0);

    // Fresh start from 0, then async reset mid-WAIT_EX with pc nonzero.
    mem[0]   = mk(JMP_OP, 9);
    mem[9]   = mk(ADD_OP, 0);
    ex_delay = 10;
    build_expect(2, 0);
    pulse_start();
    wait_drain();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("rst_wait");
    exp_q.delete();
    br_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    ex_delay = 0;

    // Randomized programs with random handshake latencies.
    rand_delay = 1'b1;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 32; i++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 6)       mem[i] = mk(HALT_OP, $urandom_range(0, 31));
        else if (r < 26) mem[i] = mk(JMP_OP, $urandom_range(0, 31));
        else if (r < 52) mem[i] = mk(BR_OP, $urandom_range(0, 31));
        else             mem[i] = mk(7'($urandom), $urandom_range(0, 31));
      end
      run_prog(25, 0, 0);
      do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
